// File: rtl/playback_sequencer_pkg.sv
// Shared types for the record/playback sequencer: controller states and bookmark count.
package playback_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_REC  = 2'd2,
    ST_FULL = 2'd3
  } seq_state_t;

  localparam int NUM_BOOKMARKS = 4;

endpackage

// File: rtl/playback_sequencer_tick_divider.sv
// Note-step tick generator: counts 0..TICK_DIV-1 while enabled, pulses tick on the last count.
module tick_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/playback_sequencer.sv
// Record/playback controller: owns the PC, recorded length, bookmarks and the memory port.
module playback_sequencer
  import playback_sequencer_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_W    = 16,
  parameter int TICK_DIV  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 sw_record,
  input  logic                 erase,
  input  logic [4:0]           btn,
  input  logic [WORD_SIZE-1:0] key,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] note,
  output logic                 note_valid,
  output logic                 recording,
  output logic                 full
);

  localparam int BM_W = $clog2(NUM_BOOKMARKS);
  localparam logic [ADDR_W:0] LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

  seq_state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W:0]   len, len_n;
  logic [ADDR_W-1:0] bookmark [NUM_BOOKMARKS];
  logic [NUM_BOOKMARKS-1:0] btn_q, btn_rise;
  logic [BM_W-1:0]   bm_sel;
  logic              bm_allowed, bm_store, mode_chg;
  logic              tick, tick_en, tick_clr;
  logic              note_load, we_c;

  // Playback wraps to the start once the last recorded note has been read.
  function automatic logic [ADDR_W-1:0] play_next(input logic [ADDR_W-1:0] p,
                                                  input logic [ADDR_W:0]   l);
    logic [ADDR_W:0] inc;
    inc = {1'b0, p} + (ADDR_W+1)'(1);
    return (inc == l) ? '0 : inc[ADDR_W-1:0];
  endfunction

  assign tick_en    = run && (state == ST_PLAY || state == ST_REC);
  assign btn_rise   = btn[NUM_BOOKMARKS-1:0] & ~btn_q;
  assign bm_allowed = (state == ST_PLAY || state == ST_IDLE) && (|btn_rise);

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    bm_sel = '0;
    for (int i = NUM_BOOKMARKS - 1; i >= 0; i--) begin
      if (btn_rise[i]) bm_sel = BM_W'(i);
    end
  end

  // Priority: erase, then mode change, then bookmark jump, then tick.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    len_n     = len;
    tick_clr  = 1'b0;
    note_load = 1'b0;
    we_c      = 1'b0;
    bm_store  = 1'b0;
    mode_chg  = 1'b0;
    if (erase) begin
      pc_n     = '0;
      len_n    = '0;
      tick_clr = 1'b1;
      if (state == ST_FULL && sw_record) state_n = ST_REC;
    end else begin
      unique case (state)
        ST_IDLE: if (run) begin
          mode_chg = 1'b1;
          if (!sw_record) begin
            state_n = ST_PLAY;
          end else begin
            pc_n    = len[ADDR_W-1:0];
            state_n = (len == LEN_FULL) ? ST_FULL : ST_REC;
          end
        end
        ST_PLAY: if (!run) begin
          mode_chg = 1'b1;
          state_n  = ST_IDLE;
        end else if (sw_record) begin
          mode_chg = 1'b1;
          pc_n     = len[ADDR_W-1:0];
          state_n  = (len == LEN_FULL) ? ST_FULL : ST_REC;
        end
        ST_REC: if (!run) begin
          mode_chg = 1'b1;
          state_n  = ST_IDLE;
        end else if (!sw_record) begin
          mode_chg = 1'b1;
          pc_n     = '0;
          state_n  = ST_PLAY;
        end
        ST_FULL: if (!sw_record) begin
          mode_chg = 1'b1;
          pc_n     = '0;
          state_n  = ST_PLAY;
        end
      endcase
      if (mode_chg) begin
        tick_clr = 1'b1;
      end else begin
        bm_store = bm_allowed && btn[4];
        if (bm_allowed && !btn[4]) begin
          pc_n     = ({1'b0, bookmark[bm_sel]} < len) ? bookmark[bm_sel] : '0;
          tick_clr = 1'b1;
        end else if (tick && state == ST_PLAY && len != '0) begin
          note_load = 1'b1;
          pc_n      = play_next(pc, len);
        end else if (tick && state == ST_REC) begin
          we_c  = 1'b1;
          len_n = len + (ADDR_W+1)'(1);
          if (&pc) state_n = ST_FULL;
          else     pc_n    = pc + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      pc         <= '0;
      len        <= '0;
      btn_q      <= '0;
      note       <= '0;
      note_valid <= 1'b0;
      recording  <= 1'b0;
      full       <= 1'b0;
      for (int i = 0; i < NUM_BOOKMARKS; i++) bookmark[i] <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      len        <= len_n;
      btn_q      <= btn[NUM_BOOKMARKS-1:0];
      note_valid <= note_load;
      recording  <= (state_n == ST_REC);
      full       <= (state_n == ST_FULL);
      if (note_load) note <= mem_rdata;
      if (bm_store) bookmark[bm_sel] <= pc;
    end
  end

  assign mem_addr  = pc;
  assign mem_wdata = key;
  assign mem_we    = we_c;

endmodule
